mlaccel_qpi_phy: RTL

// - QPI slave front-end of mlaccel_top. Samples the asynchronous host pins (qpi_csb, qpi_clk, qpi_io[3:0]) in the

---
 rtl/mlaccel_qpi_phy_if.sv | 31 +++
 rtl/mlaccel_qpi_phy.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_qpi_phy_if.sv
// Decoder-side bundle of the QPI PHY: received byte stream and send handshake.
// master = PHY, slave = command decoder. frame_err exists only with MLACCEL_QPI_FRAMEERR_EN.
interface mlaccel_qpi_phy_if;
  logic       rx_start;
  logic       rx_stop;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_mode;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ack;
`ifdef MLACCEL_QPI_FRAMEERR_EN
  logic       frame_err;
`endif

  modport master (
    input  tx_mode, tx_valid, tx_data,
    output rx_start, rx_stop, rx_valid, rx_data, tx_ack
`ifdef MLACCEL_QPI_FRAMEERR_EN
    , output frame_err
`endif
  );

  modport slave (
    output tx_mode, tx_valid, tx_data,
    input  rx_start, rx_stop, rx_valid, rx_data, tx_ack
`ifdef MLACCEL_QPI_FRAMEERR_EN
    , input frame_err
`endif
  );
endinterface

// File: rtl/mlaccel_qpi_phy.sv
// QPI slave pin front-end: synchronises and filters host pins, assembles nibbles
// into bytes and serialises response bytes onto qpi_io.
// Ports: clock/reset (async, active-high); qpi_csb/qpi_clk/qpi_io_in host pins;
// qpi_io_out/qpi_io_oe pad drive; dec = decoder bundle (mlaccel_qpi_phy_if.master).
// Option: MLACCEL_QPI_FRAMEERR_EN adds dec.frame_err on a mid-byte frame close.
module mlaccel_qpi_phy #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         FILTER_LEN    = 2,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_in,
  output logic [3:0] qpi_io_out,
  output logic       qpi_io_oe,
  mlaccel_qpi_phy_if.master dec
);

  typedef enum logic [1:0] {
    IDLE, RECV, SEND, LOCK
  } state_t;

  localparam int         BOOT    = SYNC_STAGES + FILTER_LEN;
  localparam int         BW      = $clog2(BOOT + 1);
  localparam logic [2:0] FLT_TOP = 3'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [3:0]             io_sync [SYNC_STAGES];
  logic                   csb_s;
  logic                   clk_s;
  logic [3:0]             io_s;

  assign csb_s = csb_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign io_s  = io_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csb_sync <= '1;
      clk_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++)
        io_sync[i] <= '0;
    end else begin
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], qpi_csb};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], qpi_clk};
      io_sync[0] <= qpi_io_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        io_sync[i] <= io_sync[i-1];
    end
  end

  // Level filters: a new level is accepted on its FILTER_LEN-th
  // consecutive sample; the accept strobe doubles as the edge event.
  logic       csb_f;
  logic       clk_f;
  logic [2:0] csb_cnt;
  logic [2:0] clk_cnt;
  logic       csb_acc;
  logic       clk_acc;

  assign csb_acc = (csb_s != csb_f) && (csb_cnt == FLT_TOP);
  assign clk_acc = (clk_s != clk_f) && (clk_cnt == FLT_TOP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csb_f   <= 1'b1;
      csb_cnt <= '0;
    end else if (csb_s == csb_f) begin
      csb_cnt <= '0;
    end else if (csb_acc) begin
      csb_f   <= csb_s;
      csb_cnt <= '0;
    end else begin
      csb_cnt <= csb_cnt + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_f   <= 1'b1;
      clk_cnt <= '0;
    end else if (clk_s == clk_f) begin
      clk_cnt <= '0;
    end else if (clk_acc) begin
      clk_f   <= clk_s;
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 3'd1;
    end
  end

  logic csb_fall;
  logic csb_rise;
  logic clk_rise;
  logic clk_fall;

  assign csb_fall = csb_acc & ~csb_s;
  assign csb_rise = csb_acc & csb_s;
  assign clk_rise = clk_acc & clk_s & ~csb_rise;
  assign clk_fall = clk_acc & ~clk_s & ~csb_rise;

  // A csb fall seen while the pipeline is still flushing its reset preload
  // means the host was mid-frame across reset: that frame goes to LOCK.
  logic [BW-1:0] boot;
  logic          boot_busy;

  assign boot_busy = (boot != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      boot <= BW'(BOOT);
    else if (boot_busy)
      boot <= boot - 1'b1;
  end

  state_t state;
  state_t nxt;
  logic   phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (csb_rise) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (csb_fall)
                nxt = boot_busy ? LOCK : RECV;
        RECV: if (clk_fall && dec.tx_mode && !phase)
                nxt = SEND;
        SEND: if (clk_fall && !dec.tx_mode)
                nxt = RECV;
        LOCK: nxt = LOCK;
      endcase
    end
  end

  logic       open_ev;
  logic       close_ev;
  logic       cap_en;
  logic       drv_en;
  logic       rel_en;
  logic [7:0] next_byte;

  always_comb begin
    open_ev   = 1'b0;
    close_ev  = 1'b0;
    cap_en    = 1'b0;
    drv_en    = 1'b0;
    rel_en    = 1'b0;
    next_byte = dec.tx_valid ? dec.tx_data : UNDERRUN_BYTE;
    unique case (state)
      IDLE: open_ev = csb_fall & ~boot_busy;
      RECV: begin
        close_ev = csb_rise;
        cap_en   = clk_rise;
        drv_en   = clk_fall & dec.tx_mode & ~phase;
      end
      SEND: begin
        close_ev = csb_rise;
        drv_en   = clk_fall & dec.tx_mode;
        rel_en   = clk_fall & ~dec.tx_mode;
      end
      LOCK: ;
    endcase
  end

  logic [3:0] hi_nib;
  logic [3:0] tx_lo;
  logic [7:0] rx_data_q;
  logic       rx_start_q;
  logic       rx_stop_q;
  logic       rx_valid_q;
  logic       tx_ack_q;
  logic       ferr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase      <= 1'b0;
      hi_nib     <= '0;
      tx_lo      <= '0;
      rx_data_q  <= '0;
      rx_start_q <= 1'b0;
      rx_stop_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
      ferr_q     <= 1'b0;
      qpi_io_out <= '0;
      qpi_io_oe  <= 1'b0;
    end else begin
      rx_start_q <= open_ev;
      rx_stop_q  <= close_ev;
      ferr_q     <= close_ev & phase;
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
      if (csb_rise || rel_en) begin
        phase     <= 1'b0;
        qpi_io_oe <= 1'b0;
      end else if (cap_en) begin
        if (!phase) begin
          hi_nib <= io_s;
          phase  <= 1'b1;
        end else begin
          rx_data_q  <= {hi_nib, io_s};
          rx_valid_q <= 1'b1;
          phase      <= 1'b0;
        end
      end else if (drv_en) begin
        qpi_io_oe <= 1'b1;
        if (!phase) begin
          tx_lo      <= next_byte[3:0];
          qpi_io_out <= next_byte[7:4];
          tx_ack_q   <= dec.tx_valid;
          phase      <= 1'b1;
        end else begin
          qpi_io_out <= tx_lo;
          phase      <= 1'b0;
        end
      end
    end
  end

  assign dec.rx_start = rx_start_q;
  assign dec.rx_stop  = rx_stop_q;
  assign dec.rx_valid = rx_valid_q;
  assign dec.rx_data  = rx_data_q;
  assign dec.tx_ack   = tx_ack_q;
`ifdef MLACCEL_QPI_FRAMEERR_EN
  assign dec.frame_err = ferr_q;
`else
  logic ferr_unused;
  assign ferr_unused = ferr_q;
`endif

endmodule
